// File: rtl/ula_issue_pkg.sv
// Shared widths, FSM encodings and ALU op codes for the ula_issue stage.
// The op field is one bit wider than the legal range, so the stage can detect and flag illegal codes.
package ula_issue_pkg;
    localparam int BITS  = 8;
    localparam int OP    = 4;
    localparam int NREGS = 4;
    localparam int RSEL  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [OP-1:0] OP_NOT = 4'd0;
    localparam logic [OP-1:0] OP_AND = 4'd1;
    localparam logic [OP-1:0] OP_OR  = 4'd2;
    localparam logic [OP-1:0] OP_XOR = 4'd3;
    localparam logic [OP-1:0] OP_ADD = 4'd4;
    localparam logic [OP-1:0] OP_SUB = 4'd5;
    localparam logic [OP-1:0] OP_SHL = 4'd6;
    localparam logic [OP-1:0] OP_SHR = 4'd7;

    function automatic logic op_legal(input logic [OP-1:0] op);
        return op <= OP_SHR;
    endfunction
endpackage

// File: rtl/ula_issue_reg_file.sv
// 4 x BITS architectural register file: two operand read ports, a debug read port,
// and ALU/load write ports in which the ALU write wins when both target the same register.
import ula_issue_pkg::*;

module ula_issue_reg_file (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RSEL-1:0]  rd_a_sel_i,
    input  logic [RSEL-1:0]  rd_b_sel_i,
    input  logic [RSEL-1:0]  dbg_sel_i,
    input  logic             alu_we_i,
    input  logic [RSEL-1:0]  alu_sel_i,
    input  logic [BITS-1:0]  alu_data_i,
    input  logic             ld_we_i,
    input  logic [RSEL-1:0]  ld_sel_i,
    input  logic [BITS-1:0]  ld_data_i,
    output logic [BITS-1:0]  rd_a_o,
    output logic [BITS-1:0]  rd_b_o,
    output logic [BITS-1:0]  dbg_o
);
    logic [BITS-1:0] regs_q [NREGS];
    logic [BITS-1:0] regs_d [NREGS];

    // The ALU write is applied last, so it overrides a load to the same register.
    always_comb begin
        regs_d = regs_q;
        if (ld_we_i)  regs_d[ld_sel_i]  = ld_data_i;
        if (alu_we_i) regs_d[alu_sel_i] = alu_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_o = regs_q[rd_a_sel_i];
    assign rd_b_o = regs_q[rd_b_sel_i];
    assign dbg_o  = regs_q[dbg_sel_i];
endmodule

// File: rtl/ula_issue.sv
// Execute-issue stage in front of ula: accepts one instruction every three cycles, latches the operands,
// writes the ALU result back to ra and handles a load port that can bypass into the operands.
import ula_issue_pkg::*;

module ula_issue (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             instr_valid_in,
    output logic             instr_ready_out,
    input  logic [OP-1:0]    op_in,
    input  logic [RSEL-1:0]  ra_in,
    input  logic [RSEL-1:0]  rb_in,
    input  logic             ld_valid_in,
    input  logic [RSEL-1:0]  ld_reg_in,
    input  logic [BITS-1:0]  ld_data_in,
    output logic [BITS-1:0]  ula_a_out,
    output logic [BITS-1:0]  ula_b_out,
    output logic [OP-1:0]    ula_op_out,
    input  logic [BITS-1:0]  ula_result_in,
    output logic             wb_valid_out,
    output logic [RSEL-1:0]  wb_reg_out,
    output logic [BITS-1:0]  wb_data_out,
    output logic             err_out,
    input  logic [RSEL-1:0]  dbg_sel_in,
    output logic [BITS-1:0]  dbg_data_out
);
    logic [1:0]      state_q, state_d;
    logic [OP-1:0]   op_q, op_d;
    logic [RSEL-1:0] ra_q, ra_d;
    logic [BITS-1:0] a_q, a_d, b_q, b_d;
    logic [RSEL-1:0] wb_reg_q, wb_reg_d;
    logic [BITS-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;
    logic [BITS-1:0] rd_a, rd_b, opnd_a, opnd_b;
    logic            alu_we, accept;

    ula_issue_reg_file u_reg_file (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .rd_a_sel_i (ra_in),
        .rd_b_sel_i (rb_in),
        .dbg_sel_i  (dbg_sel_in),
        .alu_we_i   (alu_we),
        .alu_sel_i  (ra_q),
        .alu_data_i (ula_result_in),
        .ld_we_i    (ld_valid_in),
        .ld_sel_i   (ld_reg_in),
        .ld_data_i  (ld_data_in),
        .rd_a_o     (rd_a),
        .rd_b_o     (rd_b),
        .dbg_o      (dbg_data_out)
    );

    assign instr_ready_out = (state_q == ST_IDLE);
    assign accept          = instr_valid_in && instr_ready_out;
    assign alu_we          = (state_q == ST_EXEC);

    // A load landing in the handshake cycle is forwarded straight into the latched operand.
    assign opnd_a = (ld_valid_in && ld_reg_in == ra_in) ? ld_data_in : rd_a;
    assign opnd_b = (ld_valid_in && ld_reg_in == rb_in) ? ld_data_in : rd_b;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ra_d      = ra_q;
        a_d       = a_q;
        b_d       = b_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_legal(op_in)) begin
                        op_d    = op_in;
                        ra_d    = ra_in;
                        a_d     = opnd_a;
                        b_d     = opnd_b;
                        state_d = ST_EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                wb_reg_d  = ra_q;
                wb_data_d = ula_result_in;
                state_d   = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ra_q      <= ra_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign ula_a_out    = a_q;
    assign ula_b_out    = b_q;
    assign ula_op_out   = op_q;
    assign wb_valid_out = (state_q == ST_WB);
    assign wb_reg_out   = wb_reg_q;
    assign wb_data_out  = wb_data_q;
    assign err_out      = err_q;
endmodule

// File: tb/tb_ula_issue.sv
// Bench for ula_issue with a behavioural ula on the result port; writebacks are scoreboarded
// against a register model, and register/operand state is checked around each instruction.
module tb_ula_issue;
    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       instr_valid_in;
    logic       instr_ready_out;
    logic [3:0] op_in;
    logic [1:0] ra_in, rb_in;
    logic       ld_valid_in;
    logic [1:0] ld_reg_in;
    logic [7:0] ld_data_in;
    logic [7:0] ula_a_out, ula_b_out;
    logic [3:0] ula_op_out;
    logic [7:0] ula_result_in;
    logic       wb_valid_out;
    logic [1:0] wb_reg_out;
    logic [7:0] wb_data_out;
    logic       err_out;
    logic [1:0] dbg_sel_in;
    logic [7:0] dbg_data_out;

    typedef struct packed { logic [1:0] r; logic [7:0] d; } wb_t;
    wb_t        exp_q[$];
    logic [7:0] mregs [4];
    logic [7:0] last_a, last_b;
    logic [3:0] last_op;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk_in = ~clk_in;

    ula_issue dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .op_in(op_in), .ra_in(ra_in), .rb_in(rb_in),
        .ld_valid_in(ld_valid_in), .ld_reg_in(ld_reg_in), .ld_data_in(ld_data_in),
        .ula_a_out(ula_a_out), .ula_b_out(ula_b_out), .ula_op_out(ula_op_out),
        .ula_result_in(ula_result_in),
        .wb_valid_out(wb_valid_out), .wb_reg_out(wb_reg_out), .wb_data_out(wb_data_out),
        .err_out(err_out), .dbg_sel_in(dbg_sel_in), .dbg_data_out(dbg_data_out)
    );

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return ~b;
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a ^ b;
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd6:    return a << b;
            4'd7:    return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb ula_result_in = alu(ula_op_out, ula_a_out, ula_b_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Writeback monitor: every pulse must match the oldest expected writeback.
    initial begin
        forever begin
            @(posedge clk_in); #1;
            if (wb_valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_valid_out), 32'd0);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_reg", 32'(wb_reg_out), 32'(e.r));
                    chk("wb_data", 32'(wb_data_out), 32'(e.d));
                end
            end
        end
    end

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel_in = 2'(i);
            #1;
            chk(tag, 32'(dbg_data_out), 32'(mregs[i]));
        end
    endtask

    task automatic do_load(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk_in);
        ld_valid_in = 1'b1; ld_reg_in = r; ld_data_in = d;
        mregs[r] = d;
        @(posedge clk_in); #1;
        ld_valid_in = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic lv, input logic [1:0] lr, input logic [7:0] ld,
                         input logic ev, input logic [1:0] er, input logic [7:0] ed,
                         input logic rst_exec);
        logic [7:0] a, b, res;
        logic       legal;
        @(negedge clk_in);
        instr_valid_in = 1'b1; op_in = op; ra_in = ra; rb_in = rb;
        ld_valid_in = lv; ld_reg_in = lr; ld_data_in = ld;
        chk("ready_idle", 32'(instr_ready_out), 32'd1);
        a = (lv && lr == ra) ? ld : mregs[ra];
        b = (lv && lr == rb) ? ld : mregs[rb];
        if (lv) mregs[lr] = ld;
        legal = (op <= 4'd7);
        res = alu(op, a, b);
        if (legal && !rst_exec) exp_q.push_back(wb_t'({ra, res}));
        @(posedge clk_in); #1;
        instr_valid_in = 1'b0; ld_valid_in = 1'b0;
        if (!legal) begin
            chk("err_pulse", 32'(err_out), 32'd1);
            chk("ready_after_err", 32'(instr_ready_out), 32'd1);
            chk("err_a_hold", 32'(ula_a_out), 32'(last_a));
            chk("err_b_hold", 32'(ula_b_out), 32'(last_b));
            chk("err_op_hold", 32'(ula_op_out), 32'(last_op));
            @(posedge clk_in); #1;
            chk("err_clear", 32'(err_out), 32'd0);
            check_regs("err_regs");
            return;
        end
        chk("ula_a", 32'(ula_a_out), 32'(a));
        chk("ula_b", 32'(ula_b_out), 32'(b));
        chk("ula_op", 32'(ula_op_out), 32'(op));
        chk("ready_exec", 32'(instr_ready_out), 32'd0);
        chk("err_legal", 32'(err_out), 32'd0);
        last_a = a; last_b = b; last_op = op;
        if (rst_exec) begin
            rst_in = 1'b1;
            @(posedge clk_in); #1;
            rst_in = 1'b0;
            for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
            last_a = 8'h00; last_b = 8'h00; last_op = 4'h0;
            chk("rst_ready", 32'(instr_ready_out), 32'd1);
            chk("rst_wb_valid", 32'(wb_valid_out), 32'd0);
            chk("rst_ula_a", 32'(ula_a_out), 32'd0);
            check_regs("rst_regs");
            repeat (3) @(posedge clk_in);
            return;
        end
        ld_valid_in = ev; ld_reg_in = er; ld_data_in = ed;
        if (ev && er != ra) mregs[er] = ed;
        mregs[ra] = res;
        @(posedge clk_in); #1;
        ld_valid_in = 1'b0;
        chk("ready_wb", 32'(instr_ready_out), 32'd0);
        dbg_sel_in = ra;
        #1;
        chk("dbg_wb", 32'(dbg_data_out), 32'(res));
        @(posedge clk_in); #1;
        chk("ready_back", 32'(instr_ready_out), 32'd1);
    endtask

    initial begin
        rst_in = 1'b1; instr_valid_in = 1'b0; op_in = '0; ra_in = '0; rb_in = '0;
        ld_valid_in = 1'b0; ld_reg_in = '0; ld_data_in = '0; dbg_sel_in = '0;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        last_a = 8'h00; last_b = 8'h00; last_op = 4'h0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        chk("reset_ready", 32'(instr_ready_out), 32'd1);
        chk("reset_a", 32'(ula_a_out), 32'd0);
        chk("reset_b", 32'(ula_b_out), 32'd0);
        chk("reset_op", 32'(ula_op_out), 32'd0);
        chk("reset_wb_valid", 32'(wb_valid_out), 32'd0);
        chk("reset_wb_reg", 32'(wb_reg_out), 32'd0);
        chk("reset_wb_data", 32'(wb_data_out), 32'd0);
        chk("reset_err", 32'(err_out), 32'd0);
        check_regs("reset_regs");

        // xor r1=9, r2=1
        do_load(2'd1, 8'd9);
        do_load(2'd2, 8'd1);
        issue(4'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("xor_result", 32'(dbg_data_out), 32'h08);
        chk("xor_wb_hold", 32'(wb_data_out), 32'h08);

        // add wraps to zero, then sub wraps back to 0xFF
        do_load(2'd0, 8'hFF);
        do_load(2'd3, 8'h01);
        issue(4'd4, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("add_wrap", 32'(dbg_data_out), 32'h00);
        issue(4'd5, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("sub_wrap", 32'(dbg_data_out), 32'hFF);

        // bypass of a same-cycle load into operand B
        issue(4'd0, 2'd1, 2'd2, 1'b1, 2'd2, 8'h55, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("not_bypass", 32'(dbg_data_out), 32'hAA);

        // load to destination during EXEC loses to the ALU result
        do_load(2'd1, 8'hFF);
        do_load(2'd2, 8'h02);
        issue(4'd6, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h11, 1'b0);
        chk("shl_alu_wins", 32'(dbg_data_out), 32'hFC);

        // load to another register during EXEC lands alongside the writeback
        issue(4'd2, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h3C, 1'b0);
        check_regs("exec_ld_other");

        // ra == rb, and bypass on operand A
        issue(4'd4, 2'd2, 2'd2, 1'b1, 2'd2, 8'h81, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("same_reg_add", 32'(dbg_data_out), 32'h02);

        // illegal op codes
        issue(4'd9, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        issue(4'd15, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 9) == 9) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            issue(rop, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0);
        end
        check_regs("random_regs");

        // reset while an instruction is in EXEC
        do_load(2'd1, 8'h44);
        issue(4'd1, 2'd1, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1);

        repeat (4) @(posedge clk_in);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
